// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit path.
//             tx_state_t            - transmitter FSM state encoding
//             c_DEFAULT_CLKS_PER_BIT - default bit period (50 MHz / 115200)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int c_DEFAULT_CLKS_PER_BIT = 434;

endpackage
`default_nettype wire

// File: rtl/baud_counter.sv
`default_nettype none
// ============================================================================
//  Module   : baud_counter
//  Purpose  : Free-running modulo-M counter that marks the last cycle of each
//             serial bit period. A clear restarts the period so that a new
//             frame always begins on a full-length start bit.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset
//             clr   - synchronous restart of the bit period
//             tick  - high while the count equals M-1
//  Revision : 1.0 - initial release
// ============================================================================
module baud_counter
    import uart_pkg::*;
#(
    parameter int M = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int                 c_CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(M - 1);

    logic [c_CNT_W-1:0] r_count;

    // Wrap is an explicit clear at M-1, so the counter never overflows even
    // when M is not a power of two.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : UART transmitter that drains a first-word-fall-through FIFO.
//             Each popped word is sent as 1 start bit, DATA_WIDTH data bits
//             LSB first and 1 stop bit; frames run back to back while the
//             FIFO holds data.
//  Ports    : clk          - system clock
//             reset        - synchronous active-high reset
//             empty        - FIFO empty flag
//             r_data       - FIFO head word (valid while empty = 0)
//             rd           - combinational pop strobe to the FIFO
//             tx           - registered serial line, idle high
//             busy         - high whenever a frame is in progress
//             tx_done_tick - one-cycle pulse on the last stop-bit cycle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done_tick
);

    localparam int                 c_IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic [c_IDX_W-1:0]    w_bit_idx_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_bit_end;
    logic                  w_pop;

    baud_counter #(
        .M (CLKS_PER_BIT)
    ) u_baud_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_pop),
        .tick  (w_bit_end)
    );

    // A pop is only possible from IDLE or in the final stop-bit cycle, which
    // is what makes back-to-back frames gapless. Gating with reset keeps the
    // FIFO untouched while the transmitter is held in reset.
    assign w_pop = ~reset & ~empty &
                   ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;

        if (w_pop) begin
            w_state_next   = START;
            w_shift_next   = r_data;
            w_bit_idx_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                START: begin
                    if (w_bit_end) begin
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        w_shift_next = r_shift >> 1;
                        if (r_bit_idx == c_LAST_IDX) begin
                            w_state_next   = STOP;
                            w_bit_idx_next = '0;
                        end else begin
                            w_bit_idx_next = r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    // A pop in this cycle was handled above; otherwise the
                    // FIFO is empty and the line returns to idle.
                    if (w_bit_end) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // tx is decoded from the next state so the registered line changes on
    // the same edge as the state register.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            IDLE:    w_tx_next = 1'b1;
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            STOP:    w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign rd           = w_pop;
    assign tx           = r_tx;
    assign busy         = (r_state != IDLE);
    assign tx_done_tick = (r_state == STOP) & w_bit_end;

endmodule
`default_nettype wire
